// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_CLKS_PER_BIT = 87;
  // Frame watchdog length in bit times (a 10-bit frame plus margin).
  localparam int TIMEOUT_BITS     = 12;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_grant+1, wrapping at NUM_REQ.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       any_vld
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    // Distance 1 is highest priority, distance NUM_REQ (the previous winner) lowest.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      for (int n = 0; n < NUM_REQ; n++) begin
        if (!found && req[n] && cand == (IDX_W+1)'(n)) begin
          gnt[n] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign any_vld = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters with round-robin arbitration.
// Optional frame watchdog and o_Timeout port enabled by UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                 o_Timeout
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               dv_q, dv_d;
  logic [7:0]         byte_q, byte_d;

  logic [NUM_REQ-1:0] win_oh;
  logic               any_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [7:0]         win_byte;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (i_Req_Valid),
    .last_grant (last_grant_q),
    .gnt        (win_oh),
    .any_vld    (any_vld)
  );

  always_comb begin
    win_idx  = '0;
    win_byte = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (win_oh[n]) begin
        win_idx  = win_idx | IDX_W'(n);
        win_byte = win_byte | i_Req_Byte[8*n +: 8];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TIMEOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W       = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ready_d      = '0;
    dv_d         = 1'b0;
    byte_d       = byte_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d        = '0;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_vld) begin
          state_d      = S_WAIT_DONE;
          last_grant_d = win_idx;
          grant_d      = win_oh;
          ready_d      = win_oh;
          dv_d         = 1'b1;
          byte_d       = win_byte;
        end
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) begin
          grant_d = '0;
          state_d = S_GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      // One idle cycle lets uart_tx finish its own cleanup before the next strobe.
      S_GAP:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      ready_q      <= '0;
      dv_q         <= 1'b0;
      byte_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ready_q      <= ready_d;
      dv_q         <= dv_d;
      byte_q       <= byte_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_Timeout = timeout_q;
`endif

  assign o_Req_Ready = ready_q;
  assign o_Grant     = grant_q;
  assign o_Tx_DV     = dv_q;
  assign o_Tx_Byte   = byte_q;
  assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle model of the arbitration rules plus directed scenarios.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           i_Clock = 1'b0;
  logic           i_Rst_n = 1'b1;
  logic [N-1:0]   i_Req_Valid = '0;
  logic [8*N-1:0] i_Req_Byte = '0;
  logic           i_Tx_Done = 1'b0;
  logic [N-1:0]   o_Req_Ready, o_Grant;
  logic           o_Tx_DV, o_Busy;
  logic [7:0]     o_Tx_Byte;
`ifdef UART_ARB_TIMEOUT_EN
  logic           o_Timeout;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(87)) dut (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Req_Valid (i_Req_Valid),
    .i_Req_Byte  (i_Req_Byte),
    .o_Req_Ready (o_Req_Ready),
    .o_Grant     (o_Grant),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Done   (i_Tx_Done),
    .o_Busy      (o_Busy)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .o_Timeout   (o_Timeout)
`endif
  );

  always #5 i_Clock = ~i_Clock;

  int vectors = 0, miscompares = 0;
  int frame_len = 20;
  bit auto_done = 1'b1;
  bit gap_chk = 1'b0;
  int last_done_edge = -1;
  int edge_n = 0;
  logic [7:0] sent_q[$];

  // Model: who owns the transmitter, whether the cleanup gap is pending, rotation pointer.
  int owner_m = -1;
  bit gap_m = 1'b0;
  int last_m = N-1;
  int byte_m = 0, dv_m = 0, rdy_m = 0, to_m = 0, wait_m = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    dv_m = 0; rdy_m = 0; to_m = 0;
    if (!i_Rst_n) begin
      owner_m = -1; gap_m = 0; last_m = N-1; byte_m = 0; wait_m = 0;
      return;
    end
    if (owner_m >= 0) begin
      if (i_Tx_Done) begin
        owner_m = -1; gap_m = 1;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else begin
        wait_m++;
        if (wait_m == 12*87) begin to_m = 1; owner_m = -1; gap_m = 1; end
      end
`endif
    end else if (gap_m) begin
      gap_m = 0;
    end else if (i_Req_Valid != 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_m + k) % N;
        if (i_Req_Valid[c]) begin owner_m = c; break; end
      end
      last_m = owner_m;
      byte_m = i_Req_Byte[8*owner_m +: 8];
      dv_m = 1;
      rdy_m = 1 << owner_m;
      wait_m = 0;
    end
  endtask

  // Per-cycle comparison against the model, sampled 1 time unit after each rising edge.
  initial forever begin
    @(posedge i_Clock);
    edge_n++;
    if (i_Rst_n && i_Tx_Done && owner_m >= 0) last_done_edge = edge_n;
    model_step();
    #1;
    chk("tx_dv", o_Tx_DV, dv_m);
    chk("req_ready", o_Req_Ready, rdy_m);
    chk("grant", o_Grant, owner_m >= 0 ? (1 << owner_m) : 0);
    chk("busy", o_Busy, (owner_m >= 0 || gap_m) ? 1 : 0);
    if (owner_m >= 0) chk("tx_byte", o_Tx_Byte, byte_m);
`ifdef UART_ARB_TIMEOUT_EN
    chk("timeout", o_Timeout, to_m);
`endif
    if (o_Tx_DV) begin
      sent_q.push_back(o_Tx_Byte);
      if (gap_chk && last_done_edge >= 0) chk("dv_after_done", edge_n - last_done_edge, 2);
    end
  end

  // Stand-in for uart_tx: pulses i_Tx_Done frame_len cycles after each strobe; reset aborts it.
  initial forever begin
    @(negedge i_Clock);
    if (auto_done && i_Rst_n && o_Tx_DV) begin
      bit ab;
      ab = 1'b0;
      for (int k = 0; k < frame_len; k++) begin
        @(negedge i_Clock);
        if (!i_Rst_n) begin ab = 1'b1; break; end
      end
      if (!ab) begin
        i_Tx_Done = 1'b1;
        @(negedge i_Clock);
        i_Tx_Done = 1'b0;
      end
    end
  end

  task automatic wait_ready(input int mask, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge i_Clock); #1;
      if ((int'(o_Req_Ready) & mask) != 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk($sformatf("wait_ready_%0h", mask), 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge i_Clock); #1;
      if (!o_Busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wait_idle", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge i_Clock);
    i_Rst_n = 1'b0;
    i_Req_Valid = '0;
    repeat (2) @(negedge i_Clock);
    i_Rst_n = 1'b1;
  endtask

  function automatic int sent_at(input int i);
    return (i < sent_q.size()) ? int'(sent_q[i]) : -1;
  endfunction

  initial begin
    #2 i_Rst_n = 1'b0;
    repeat (3) @(negedge i_Clock);
    chk("rst_dv", o_Tx_DV, 0);
    chk("rst_ready", o_Req_Ready, 0);
    chk("rst_grant", o_Grant, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_byte", o_Tx_Byte, 0);
    i_Rst_n = 1'b1;

    // Single requester: latency, one-cycle accept, byte delivered.
    sent_q.delete();
    @(negedge i_Clock);
    i_Req_Byte[8*2 +: 8] = 8'hAB;
    i_Req_Valid = 4'b0100;
    @(posedge i_Clock); #1;
    chk("single_dv_latency", o_Tx_DV, 1);
    chk("single_ready", o_Req_Ready, 4'b0100);
    chk("single_byte", o_Tx_Byte, 8'hAB);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    @(posedge i_Clock); #1;
    chk("single_ready_pulse", o_Req_Ready, 0);
    chk("single_dv_pulse", o_Tx_DV, 0);
    wait_idle(200);
    chk("single_frames", sent_q.size(), 1);
    chk("single_sent", sent_at(0), 8'hAB);

    // All requesters valid: rotation from requester 0 with wrap, 2-edge done-to-strobe spacing.
    do_reset();
    sent_q.delete();
    last_done_edge = -1;
    gap_chk = 1'b1;
    @(negedge i_Clock);
    i_Req_Byte = {8'h43, 8'h32, 8'h21, 8'h10};
    i_Req_Valid = 4'b1111;
    for (int f = 0; f < 5; f++) wait_ready(4'hF, 200);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    wait_idle(200);
    gap_chk = 1'b0;
    chk("rr_frames", sent_q.size(), 5);
    chk("rr_0", sent_at(0), 8'h10);
    chk("rr_1", sent_at(1), 8'h21);
    chk("rr_2", sent_at(2), 8'h32);
    chk("rr_3", sent_at(3), 8'h43);
    chk("rr_4", sent_at(4), 8'h10);

    // Late request during a frame waits for done and the gap.
    do_reset();
    sent_q.delete();
    last_done_edge = -1;
    gap_chk = 1'b1;
    @(negedge i_Clock);
    i_Req_Byte = {8'h00, 8'h00, 8'h66, 8'h55};
    i_Req_Valid = 4'b0001;
    wait_ready(4'b0001, 50);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    repeat (3) @(negedge i_Clock);
    i_Req_Valid = 4'b0010;
    wait_ready(4'b0010, 200);
    chk("late_ready", o_Req_Ready, 4'b0010);
    chk("late_byte", o_Tx_Byte, 8'h66);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    wait_idle(200);
    gap_chk = 1'b0;
    chk("late_first", sent_at(0), 8'h55);
    chk("late_second", sent_at(1), 8'h66);

    // Reset 3000 ns into a frame, then a tie between 3 and 0 after release.
    do_reset();
    frame_len = 500;
    @(negedge i_Clock);
    i_Req_Byte = {8'h00, 8'h77, 8'h00, 8'h00};
    i_Req_Valid = 4'b0100;
    wait_ready(4'b0100, 50);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    repeat (300) @(posedge i_Clock);
    #3 i_Rst_n = 1'b0;
    #1;
    chk("midrst_dv", o_Tx_DV, 0);
    chk("midrst_ready", o_Req_Ready, 0);
    chk("midrst_grant", o_Grant, 0);
    chk("midrst_busy", o_Busy, 0);
    chk("midrst_byte", o_Tx_Byte, 0);
    frame_len = 20;
    repeat (2) @(negedge i_Clock);
    i_Req_Byte = {8'h99, 8'h00, 8'h00, 8'h88};
    i_Req_Valid = 4'b1001;
    i_Rst_n = 1'b1;
    wait_ready(4'hF, 50);
    chk("postrst_ready", o_Req_Ready, 4'b0001);
    chk("postrst_byte", o_Tx_Byte, 8'h88);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    wait_idle(200);

    // Stray done while idle has no effect; next request is still served normally.
    @(negedge i_Clock);
    i_Tx_Done = 1'b1;
    @(negedge i_Clock);
    i_Tx_Done = 1'b0;
    @(posedge i_Clock); #1;
    chk("stray_busy", o_Busy, 0);
    chk("stray_dv", o_Tx_DV, 0);
    chk("stray_grant", o_Grant, 0);
    @(negedge i_Clock);
    i_Req_Byte = {8'h00, 8'h00, 8'h5A, 8'h00};
    i_Req_Valid = 4'b0010;
    wait_ready(4'b0010, 50);
    chk("stray_next_byte", o_Tx_Byte, 8'h5A);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    wait_idle(200);

`ifdef UART_ARB_TIMEOUT_EN
    // Done never arrives: watchdog fires 12*87 cycles after the strobe.
    auto_done = 1'b0;
    @(negedge i_Clock);
    i_Req_Byte = {8'h00, 8'h3C, 8'hC3, 8'h00};
    i_Req_Valid = 4'b0010;
    wait_ready(4'b0010, 50);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    begin
      int k;
      k = 0;
      for (int c = 1; c <= 1100; c++) begin
        @(posedge i_Clock); #1;
        if (o_Timeout) begin k = c; break; end
      end
      chk("timeout_cycles", k, 1044);
    end
    auto_done = 1'b1;
    @(negedge i_Clock);
    i_Req_Valid = 4'b0100;
    wait_ready(4'b0100, 50);
    chk("after_timeout_byte", o_Tx_Byte, 8'h3C);
    @(negedge i_Clock);
    i_Req_Valid = '0;
    wait_idle(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
